ili_pio_ctrl: RTL and testbench

Parametrised Avalon-MM parallel I/O slave for the TFT/SD panel control lines (LCD reset, backlight, chip selects, card-detect, touch IRQ). It supersedes the single-bit output ports with a WIDTH-bit register bank that provides:
- atomic bit set/clear,
- per-bit direction,
- self-timed output pulses (e.g. a panel reset pulse without CPU delay loops),
- synchronised inputs with edge capture and a maskable interrupt.

---
 rtl/ili_pio_ctrl_if.sv | 22 ++
 rtl/ili_pio_ctrl.sv | 152 +++++++++++++++
 tb/tb_ili_pio_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ili_pio_ctrl_if.sv
// Avalon-MM slave bus bundle for the panel parallel I/O block.
// The master drives the address and write strobes; the slave returns
// zero-latency read data.
interface ili_pio_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/ili_pio_ctrl.sv
// Parallel I/O slave for TFT/SD panel control lines.
// It provides atomic set/clear, per-bit direction and self-timed output
// pulses. Inputs are synchronised, and their edges are captured into a
// maskable interrupt.
module ili_pio_ctrl #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '1,
    parameter logic [WIDTH-1:0] DIR_RESET    = '1,
    parameter int               EDGE_TYPE    = 0,
    parameter int               PULSE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    ili_pio_ctrl_if.slave    bus,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);
    localparam int              CW        = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [CW-1:0]   PCNT_LOAD = CW'(PULSE_CYCLES - 1);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE    = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
    localparam logic [2:0] ADDR_PULSE   = 3'd6;
    localparam logic [2:0] ADDR_INPUT   = 3'd7;

    logic [WIDTH-1:0] data_out_reg;
    logic [WIDTH-1:0] dir_reg;
    logic [WIDTH-1:0] irq_mask_reg;
    logic [WIDTH-1:0] edge_cap_reg;
    logic [WIDTH-1:0] pulse_mask_reg;
    logic [CW-1:0]    pcnt_reg;
    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [WIDTH-1:0] prev_reg;
    logic [1:0]       warm_reg;

    logic             wr_en;
    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] edge_detected;
    logic [WIDTH-1:0] edge_clr;

    assign wr_en = bus.chipselect & ~bus.write_n;

    // Output data register, which also applies the atomic set/clear aliases.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_reg <= RESET_VALUE;
        end else if (wr_en) begin
            case (bus.address)
                ADDR_DATA:   data_out_reg <= bus.writedata;
                ADDR_OUTSET: data_out_reg <= data_out_reg | bus.writedata;
                ADDR_OUTCLR: data_out_reg <= data_out_reg & ~bus.writedata;
                default:     data_out_reg <= data_out_reg;
            endcase
        end
    end

    // Direction and interrupt mask registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_reg      <= DIR_RESET;
            irq_mask_reg <= '0;
        end else if (wr_en) begin
            if (bus.address == ADDR_DIR)     dir_reg      <= bus.writedata;
            if (bus.address == ADDR_IRQMASK) irq_mask_reg <= bus.writedata;
        end
    end

    // Pulse engine. A new write always restarts the pulse with a full count,
    // and a write of zero cancels it. Otherwise a busy mask counts down and
    // self-clears on the edge where the count is already zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_mask_reg <= '0;
            pcnt_reg       <= '0;
        end else if (wr_en && bus.address == ADDR_PULSE) begin
            pulse_mask_reg <= bus.writedata;
            pcnt_reg       <= PCNT_LOAD;
        end else if (pulse_mask_reg != '0) begin
            if (pcnt_reg == '0) begin
                pulse_mask_reg <= '0;
            end else begin
                pcnt_reg <= pcnt_reg - 1'b1;
            end
        end
    end

    // Two-flop synchroniser, plus a delayed copy used for edge comparison
    // and a warm-up counter that masks edges until the pipeline holds real pin data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            prev_reg  <= '0;
            warm_reg  <= '0;
        end else begin
            sync1_reg <= in_port;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            if (warm_reg != 2'd3) warm_reg <= warm_reg + 2'd1;
        end
    end

    // Per-bit edge detector selected at elaboration time.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
        if (EDGE_TYPE == 0) begin : g_rise
            assign edge_raw[gi] = sync2_reg[gi] & ~prev_reg[gi];
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign edge_raw[gi] = ~sync2_reg[gi] & prev_reg[gi];
        end else begin : g_any
            assign edge_raw[gi] = sync2_reg[gi] ^ prev_reg[gi];
        end
    end

    assign edge_detected = (warm_reg == 2'd3) ? edge_raw : '0;
    assign edge_clr      = (wr_en && bus.address == ADDR_EDGE) ? bus.writedata : '0;

    // Edge capture. The clear is applied before the OR, so a new edge on
    // the same cycle as its write-1-to-clear keeps the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap_reg <= '0;
        end else begin
            edge_cap_reg <= (edge_cap_reg & ~edge_clr) | edge_detected;
        end
    end

    // Zero-latency read multiplexer. Write-only aliases read as zero.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:    bus.readdata = data_out_reg;
            ADDR_DIR:     bus.readdata = dir_reg;
            ADDR_IRQMASK: bus.readdata = irq_mask_reg;
            ADDR_EDGE:    bus.readdata = edge_cap_reg;
            ADDR_PULSE:   bus.readdata = pulse_mask_reg;
            ADDR_INPUT:   bus.readdata = sync2_reg;
            default:      bus.readdata = '0;
        endcase
    end

    assign out_port = data_out_reg ^ pulse_mask_reg;
    assign oe       = dir_reg;
    assign irq      = |(edge_cap_reg & irq_mask_reg);

endmodule

// File: tb/tb_ili_pio_ctrl.sv
// Self-checking bench for ili_pio_ctrl (WIDTH=8, PULSE_CYCLES=4, rising edges).
// The reference model tracks registers by cycle number. Pulses end at an
// absolute cycle, and edges are derived from the recorded pin history.
module tb_ili_pio_ctrl;
    localparam int W = 8;
    localparam int P = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] in_port = 8'hFF;
    logic [W-1:0] out_port;
    logic [W-1:0] oe;
    logic         irq;

    ili_pio_ctrl_if #(.WIDTH(W)) bus();

    ili_pio_ctrl #(
        .WIDTH        (W),
        .RESET_VALUE  (8'hFF),
        .DIR_RESET    (8'hFF),
        .EDGE_TYPE    (0),
        .PULSE_CYCLES (P)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .in_port  (in_port),
        .out_port (out_port),
        .oe       (oe),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [7:0] m_data, m_dir, m_imask, m_edge, m_pmask;
    int         m_pend;
    logic [7:0] in_hist [0:4095];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hist(input int i);
        return (i < 1) ? 8'h00 : in_hist[i];
    endfunction

    function automatic logic [7:0] exp_read(input logic [2:0] a);
        case (a)
            3'd0:    return m_data;
            3'd1:    return m_dir;
            3'd2:    return m_imask;
            3'd3:    return m_edge;
            3'd6:    return m_pmask;
            3'd7:    return hist(cyc - 1);
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_data  = 8'hFF;
        m_dir   = 8'hFF;
        m_imask = 8'h00;
        m_edge  = 8'h00;
        m_pmask = 8'h00;
        m_pend  = 0;
        cyc     = 0;
    endtask

    task automatic check_all();
        chk("out_port", out_port, m_data ^ m_pmask);
        chk("oe", oe, m_dir);
        chk("irq", {7'b0, irq}, {7'b0, |(m_edge & m_imask)});
        chk($sformatf("readdata[%0d]", bus.address), bus.readdata, exp_read(bus.address));
    endtask

    // One clock edge: update the model from the inputs seen at the edge, then check.
    task automatic tick();
        logic       w;
        logic [2:0] a;
        logic [7:0] d;
        logic [7:0] det;
        @(posedge clk);
        w = bus.chipselect && !bus.write_n;
        a = bus.address;
        d = bus.writedata;
        cyc++;
        in_hist[cyc] = in_port;
        // A pin change sampled at edge K is captured at edge K+2, once warmed up.
        det = (cyc >= 4) ? (hist(cyc - 2) & ~hist(cyc - 3)) : 8'h00;
        if (m_pmask != 8'h00 && cyc >= m_pend) m_pmask = 8'h00;
        if (w) begin
            case (a)
                3'd0: m_data  = d;
                3'd1: m_dir   = d;
                3'd2: m_imask = d;
                3'd3: m_edge  = m_edge & ~d;
                3'd4: m_data  = m_data | d;
                3'd5: m_data  = m_data & ~d;
                3'd6: begin m_pmask = d; m_pend = cyc + P; end
                default: ;
            endcase
        end
        m_edge = m_edge | det;
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a);
        bus.address = a;
        tick();
    endtask

    initial begin
        int low;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 8'h00;
        model_reset();

        // Reset state, with pins held high through the release.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_port", out_port, 8'hFF);
        chk("rst_oe", oe, 8'hFF);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        reset_n = 1'b1;
        check_all();
        for (int i = 0; i < 8; i++) rd(3'(i));
        idle(10);
        rd(3'd3);
        chk("warmup_no_edge", bus.readdata, 8'h00);

        // Set and clear.
        wr(3'd0, 8'h0F);
        wr(3'd4, 8'h30);
        chk("outset", out_port, 8'h3F);
        wr(3'd5, 8'h03);
        chk("outclr", out_port, 8'h3C);

        // Single pulse of exactly P cycles.
        wr(3'd0, 8'hFF);
        wr(3'd6, 8'h01);
        chk("pulse_start", out_port, 8'hFE);
        low = (out_port[0] == 1'b0) ? 1 : 0;
        repeat (8) begin tick(); if (out_port[0] == 1'b0) low++; end
        chk("pulse_len", 8'(low), 8'(P));

        // Re-issuing the pulse two cycles in extends the low period to 6 cycles.
        wr(3'd6, 8'h01);
        low = 1;
        tick(); if (out_port[0] == 1'b0) low++;
        wr(3'd6, 8'h01); if (out_port[0] == 1'b0) low++;
        repeat (8) begin tick(); if (out_port[0] == 1'b0) low++; end
        chk("pulse_restart_len", 8'(low), 8'd6);

        // Cancelling, and an OUTCLR issued mid-pulse.
        wr(3'd6, 8'h01);
        wr(3'd6, 8'h00);
        chk("pulse_cancel", {7'b0, out_port[0]}, 8'h01);
        wr(3'd6, 8'h01);
        wr(3'd5, 8'h01);
        chk("outclr_mid_pulse", {7'b0, out_port[0]}, 8'h01);
        idle(3);
        chk("outclr_after_pulse", {7'b0, out_port[0]}, 8'h00);
        wr(3'd0, 8'hFF);

        // Rising-edge capture and interrupt.
        wr(3'd2, 8'h80);
        in_port = 8'h7F;
        idle(4);
        in_port = 8'hFF;
        tick();
        tick();
        chk("irq_not_yet", {7'b0, irq}, 8'h00);
        tick();
        chk("irq_rise", {7'b0, irq}, 8'h01);
        wr(3'd3, 8'h80);
        chk("irq_w1c", {7'b0, irq}, 8'h00);
        in_port = 8'h7F;
        idle(5);
        chk("falling_no_capture", {7'b0, irq}, 8'h00);
        in_port = 8'hFF;
        tick();
        tick();
        wr(3'd3, 8'h80);
        chk("w1c_set_wins", {7'b0, irq}, 8'h01);
        wr(3'd3, 8'h80);

        // A post-warm-up 0->1 toggle on bit 0 is captured.
        in_port = 8'hFE;
        idle(4);
        in_port = 8'hFF;
        idle(3);
        rd(3'd3);
        chk("edge_bit0", {7'b0, bus.readdata[0]}, 8'h01);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
            if ($urandom_range(0, 9) < 4) wr(3'($urandom_range(0, 7)), 8'($urandom));
            else rd(3'($urandom_range(0, 7)));
        end

        // Reset asserted mid-pulse forces reset values, and the pulse does not resume.
        wr(3'd0, 8'h00);
        bus.address = 3'd6;
        wr(3'd6, 8'h0F);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_out_port", out_port, 8'hFF);
        chk("midrst_oe", oe, 8'hFF);
        chk("midrst_irq", {7'b0, irq}, 8'h00);
        chk("midrst_pulse_rd", bus.readdata, 8'h00);
        model_reset();
        in_port = 8'hA5;
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        check_all();
        idle(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
